bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the shared 32-bit strobe/ack system bus. It lets the CPU (master 0) and a DMA/video-fetch engine (master 1) share the single slave path that feeds the bank decoder (RAM, LED, video, UART). Arbitration is round-robin with a single outstanding transaction. A watchdog terminates transactions that are never acknowledged, so a dead bank cannot hang either master.

---
 rtl/bus_pkg.sv | 31 +++
 rtl/bus_arbiter_if.sv | 55 +++++
 rtl/bus_watchdog.sv | 35 +++
 rtl/bus_arbiter.sv | 110 +++++++++++
 tb/tb_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions for the two-master strobe/ack arbiter: widths, FSM codes, request bundle.
// Imported by the interface, the arbiter and its watchdog.
package bus_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [DAT_W-1:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
  } req_t;

  // Round-robin pick: a tie goes to the master that did not complete last.
  function automatic logic pick_master(input logic stb0, input logic stb1, input logic last);
    if (stb0 && stb1) begin
      return ~last;
    end else if (stb1) begin
      return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the shared slave path.
// slave modport is the arbiter's view; master modport is the surrounding system's view.
interface bus_arbiter_if;
  import bus_pkg::*;

  logic             m0_stb_i;
  logic             m0_we_i;
  logic [ADR_W-1:0] m0_adr_i;
  logic [DAT_W-1:0] m0_dat_i;
  logic [SEL_W-1:0] m0_sel_i;
  logic             m0_ack_o;
  logic [DAT_W-1:0] m0_dat_o;

  logic             m1_stb_i;
  logic             m1_we_i;
  logic [ADR_W-1:0] m1_adr_i;
  logic [DAT_W-1:0] m1_dat_i;
  logic [SEL_W-1:0] m1_sel_i;
  logic             m1_ack_o;
  logic [DAT_W-1:0] m1_dat_o;

  logic             s_stb_o;
  logic             s_we_o;
  logic [ADR_W-1:0] s_adr_o;
  logic [DAT_W-1:0] s_dat_o;
  logic [SEL_W-1:0] s_sel_o;
  logic             s_ack_i;
  logic [DAT_W-1:0] s_dat_i;

  logic             gnt_o;
  logic             busy_o;
  logic             err_o;
  logic [ADR_W-1:0] err_adr_o;

  modport slave (
    input  m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    output m0_ack_o, m0_dat_o,
    input  m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    output m1_ack_o, m1_dat_o,
    output s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_ack_i, s_dat_i,
    output gnt_o, busy_o, err_o, err_adr_o
  );

  modport master (
    output m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    input  m0_ack_o, m0_dat_o,
    output m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    input  m1_ack_o, m1_dat_o,
    input  s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_dat_i,
    input  gnt_o, busy_o, err_o, err_adr_o
  );

endinterface

// File: rtl/bus_watchdog.sv
// Saturating cycle counter with synchronous clear; hit_o flags count == TIMEOUT.
// Count is visible on hit_o the cycle after the enabling cycle; no backpressure.
module bus_watchdog #(
  parameter int TIMEOUT = 255,
  localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the strobe/ack bus, one outstanding transaction, watchdog abort.
// Grant 1 cycle after request; slave ack/data pass through combinationally; losing master is held off (ack=0).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int               TIMEOUT  = 255,
  parameter logic [DAT_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input logic          clk,
  input logic          rst_i,
  bus_arbiter_if.slave bus
);

  logic [0:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [ADR_W-1:0] err_adr_q, err_adr_d;

  req_t             m0_req, m1_req, g_req;
  logic             busy, g_stb, wd_hit;
  logic             done, tmo, abort;
  logic             ack_g;
  logic [DAT_W-1:0] dat_g;

  always_comb begin
    m0_req = {bus.m0_we_i, bus.m0_adr_i, bus.m0_dat_i, bus.m0_sel_i};
    m1_req = {bus.m1_we_i, bus.m1_adr_i, bus.m1_dat_i, bus.m1_sel_i};
    g_req  = gnt_q ? m1_req : m0_req;
  end

  assign busy  = (state_q == ST_BUSY);
  assign g_stb = gnt_q ? bus.m1_stb_i : bus.m0_stb_i;

  // A slave ack in the same cycle as the watchdog hit is a normal completion.
  assign done  = busy & g_stb & bus.s_ack_i;
  assign tmo   = busy & g_stb & ~bus.s_ack_i & wd_hit;
  assign abort = busy & ~g_stb;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst_i),
    .clr_i(~busy),
    .en_i (busy & ~bus.s_ack_i),
    .hit_o(wd_hit)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    err_adr_d = err_adr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.m0_stb_i || bus.m1_stb_i) begin
          gnt_d   = pick_master(bus.m0_stb_i, bus.m1_stb_i, last_q);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done || tmo) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end else if (abort) begin
          state_d = ST_IDLE;
        end
        if (tmo) begin
          err_adr_d = g_req.adr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      err_adr_q <= err_adr_d;
    end
  end

  // Slave path is forced to zero outside BUSY so reset clears every output at once.
  assign bus.s_stb_o = busy & g_stb & ~tmo;
  assign bus.s_we_o  = busy & g_req.we;
  assign bus.s_adr_o = busy ? g_req.adr : '0;
  assign bus.s_dat_o = busy ? g_req.dat : '0;
  assign bus.s_sel_o = busy ? g_req.sel : '0;

  assign ack_g = done | tmo;
  assign dat_g = !busy ? '0 : (tmo ? ERR_DATA : bus.s_dat_i);

  assign bus.m0_ack_o = ~gnt_q & ack_g;
  assign bus.m0_dat_o = gnt_q ? '0 : dat_g;
  assign bus.m1_ack_o = gnt_q & ack_g;
  assign bus.m1_dat_o = gnt_q ? dat_g : '0;

  assign bus.gnt_o     = gnt_q;
  assign bus.busy_o    = busy;
  assign bus.err_o     = tmo;
  assign bus.err_adr_o = err_adr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised and directed bench for bus_arbiter against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  bus_arbiter_if bif ();

  bus_arbiter #(
    .TIMEOUT (TMO),
    .ERR_DATA(32'hFFFF_FFFF)
  ) dut (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (bif.slave)
  );

  int nchk = 0;
  int nerr = 0;

  // Model: owner of the bus (-1 = none), BUSY cycles already elapsed, round-robin memory.
  int          cur = -1, age = 0, last_m = 1, gnt_m = 0;
  logic [31:0] eadr_m = '0;
  int          cur_n, age_n, last_n, gnt_n;
  logic [31:0] eadr_n;

  logic        snap_sstb = 0, snap_ack0 = 0, snap_ack1 = 0, snap_err = 0;
  logic        snap_gnt = 0, snap_busy = 0;
  logic [31:0] snap_dat0 = '0, snap_dat1 = '0, snap_sadr = '0, snap_eadr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic        stb_v[2], we_v[2], e_ack[2];
    logic [31:0] adr_v[2], dat_v[2], e_rd[2];
    logic [3:0]  sel_v[2];
    logic        sack, tmo, e_sstb, e_swe;
    logic [31:0] e_sadr, e_sdat;
    logic [3:0]  e_ssel;
    int          pick;
    stb_v[0] = bif.m0_stb_i; we_v[0] = bif.m0_we_i; adr_v[0] = bif.m0_adr_i;
    dat_v[0] = bif.m0_dat_i; sel_v[0] = bif.m0_sel_i;
    stb_v[1] = bif.m1_stb_i; we_v[1] = bif.m1_we_i; adr_v[1] = bif.m1_adr_i;
    dat_v[1] = bif.m1_dat_i; sel_v[1] = bif.m1_sel_i;
    sack = bif.s_ack_i;
    tmo = 0; e_sstb = 0; e_swe = 0; e_sadr = '0; e_sdat = '0; e_ssel = '0;
    e_ack[0] = 0; e_ack[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
    cur_n = cur; age_n = age; last_n = last_m; gnt_n = gnt_m; eadr_n = eadr_m;
    if (cur >= 0) begin
      tmo = stb_v[cur] && !sack && (age == TMO);
      e_sstb = stb_v[cur] && !tmo;
      e_swe  = we_v[cur];
      e_sadr = adr_v[cur];
      e_sdat = dat_v[cur];
      e_ssel = sel_v[cur];
      e_ack[cur] = stb_v[cur] && (sack || tmo);
      e_rd[cur]  = tmo ? 32'hFFFF_FFFF : bif.s_dat_i;
      if (stb_v[cur] && (sack || tmo)) begin
        last_n = cur;
        cur_n  = -1;
        if (tmo) eadr_n = adr_v[cur];
      end else if (!stb_v[cur]) begin
        cur_n = -1;
      end else begin
        age_n = age + 1;
      end
    end else if (stb_v[0] || stb_v[1]) begin
      pick  = (stb_v[0] && stb_v[1]) ? 1 - last_m : (stb_v[0] ? 0 : 1);
      cur_n = pick;
      gnt_n = pick;
      age_n = 0;
    end
    chk("s_stb", bif.s_stb_o, e_sstb);
    chk("s_we", bif.s_we_o, e_swe);
    chk("s_adr", bif.s_adr_o, e_sadr);
    chk("s_dat", bif.s_dat_o, e_sdat);
    chk("s_sel", bif.s_sel_o, e_ssel);
    chk("m0_ack", bif.m0_ack_o, e_ack[0]);
    chk("m1_ack", bif.m1_ack_o, e_ack[1]);
    chk("m0_dat", bif.m0_dat_o, e_rd[0]);
    chk("m1_dat", bif.m1_dat_o, e_rd[1]);
    chk("err", bif.err_o, tmo);
    chk("gnt", bif.gnt_o, gnt_m[0]);
    chk("busy", bif.busy_o, cur >= 0);
    chk("err_adr", bif.err_adr_o, eadr_m);
    snap_sstb = bif.s_stb_o; snap_ack0 = bif.m0_ack_o; snap_ack1 = bif.m1_ack_o;
    snap_err = bif.err_o; snap_gnt = bif.gnt_o; snap_busy = bif.busy_o;
    snap_dat0 = bif.m0_dat_o; snap_dat1 = bif.m1_dat_o; snap_sadr = bif.s_adr_o;
    snap_eadr = bif.err_adr_o;
  endtask

  always @(negedge clk) begin
    if (!rst_i) compare_cycle();
  end

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cur <= -1; age <= 0; last_m <= 1; gnt_m <= 0; eadr_m <= '0;
    end else begin
      cur <= cur_n; age <= age_n; last_m <= last_n; gnt_m <= gnt_n; eadr_m <= eadr_n;
    end
  end

  task automatic set_m(input int m, input logic stb, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      bif.m0_stb_i = stb; bif.m0_we_i = we; bif.m0_adr_i = adr; bif.m0_dat_i = dat; bif.m0_sel_i = sel;
    end else begin
      bif.m1_stb_i = stb; bif.m1_we_i = we; bif.m1_adr_i = adr; bif.m1_dat_i = dat; bif.m1_sel_i = sel;
    end
  endtask

  task automatic drop(input int m);
    if (m == 0) bif.m0_stb_i = 1'b0;
    else        bif.m1_stb_i = 1'b0;
  endtask

  task automatic new_req(input int m);
    set_m(m, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, bif.s_stb_o, bif.s_we_o, bif.m0_ack_o, bif.m1_ack_o, bif.err_o, bif.busy_o}, '0);
    chk({tag, "_gnt"}, bif.gnt_o, '0);
    chk({tag, "_sadr"}, bif.s_adr_o, '0);
    chk({tag, "_sdat"}, bif.s_dat_o, '0);
    chk({tag, "_ssel"}, bif.s_sel_o, '0);
    chk({tag, "_m0dat"}, bif.m0_dat_o, '0);
    chk({tag, "_m1dat"}, bif.m1_dat_o, '0);
    chk({tag, "_eadr"}, bif.err_adr_o, '0);
  endtask

  initial begin : watchdog_timer
    #2_000_000;
    $display("FAIL sim_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    bit found;
    rst_i = 1'b0;
    set_m(0, 0, 0, 32'h1111_0000, 32'h2222_0000, 4'hF);
    set_m(1, 0, 0, 32'h3333_0000, 32'h4444_0000, 4'hF);
    bif.s_ack_i = 1'b0;
    bif.s_dat_i = 32'h5555_AAAA;
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;

    // Contention from reset: grants alternate starting with m0, 2 cycles each.
    set_m(0, 1, 0, 32'h0000_0100, 32'h0, 4'hF);
    set_m(1, 1, 1, 32'h0000_0200, 32'hAB, 4'h3);
    bif.s_ack_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("cont_busy", snap_busy, 32'(i % 2));
      if (i % 2 == 1) begin
        chk("cont_gnt", snap_gnt, 32'((i / 2) % 2));
        chk("cont_adr", snap_sadr, ((i / 2) % 2) ? 32'h0000_0200 : 32'h0000_0100);
      end
    end
    drop(0); drop(1);
    step();

    // Single zero-wait read from m0.
    set_m(0, 1, 0, 32'h0000_0010, 32'h0, 4'hF);
    bif.s_dat_i = 32'h1234_5678;
    step();
    chk("rd_stb_first", snap_sstb, 0);
    step();
    chk("rd_stb", snap_sstb, 1);
    chk("rd_ack", snap_ack0, 1);
    chk("rd_dat", snap_dat0, 32'h1234_5678);
    chk("rd_m1ack", snap_ack1, 0);
    drop(0);
    step();
    chk("rd_ack_once", snap_ack0, 0);

    // Timeout: m1 write, slave silent.
    set_m(1, 1, 1, 32'h0400_0000, 32'hDEAD_0001, 4'hF);
    bif.s_ack_i = 1'b0;
    step();
    found = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (snap_ack1) begin
        chk("tmo_cycle", k, 5);
        chk("tmo_err", snap_err, 1);
        chk("tmo_dat", snap_dat1, 32'hFFFF_FFFF);
        found = 1;
        break;
      end
    end
    if (!found) chk("tmo_seen", 0, 1);
    drop(1);
    step();
    chk("tmo_idle", snap_busy, 0);
    chk("tmo_err_pulse", snap_err, 0);
    chk("tmo_eadr", snap_eadr, 32'h0400_0000);

    // Slave ack coincides with watchdog hit.
    set_m(0, 1, 0, 32'h0000_0020, 32'h0, 4'hF);
    bif.s_dat_i = 32'hCAFE_0004;
    step();
    for (int k = 1; k <= 4; k++) step();
    bif.s_ack_i = 1'b1;
    step();
    chk("coll_ack", snap_ack0, 1);
    chk("coll_dat", snap_dat0, 32'hCAFE_0004);
    chk("coll_err", snap_err, 0);
    drop(0);
    bif.s_ack_i = 1'b0;
    step();
    chk("coll_eadr_sticky", snap_eadr, 32'h0400_0000);

    // Async reset in the middle of a wait-state transaction.
    set_m(0, 1, 0, 32'h0000_0030, 32'h0, 4'hF);
    step();
    step();
    #2;
    rst_i = 1'b1;
    set_m(1, 1, 0, 32'h0000_0031, 32'h0, 4'hF);
    bif.s_ack_i = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    step();
    step();
    chk("rst_tie_gnt", snap_gnt, 0);
    chk("rst_tie_busy", snap_busy, 1);
    chk("rst_tie_ack", snap_ack0, 1);
    drop(0);
    step();
    step();
    chk("rst_next_gnt", snap_gnt, 1);
    drop(1);
    bif.s_ack_i = 1'b0;
    step();

    // Master abort while m1 waits.
    set_m(0, 1, 0, 32'h0000_0040, 32'h0, 4'hF);
    step();
    set_m(1, 1, 1, 32'h0000_0050, 32'h77, 4'h1);
    step();
    chk("abort_holdoff", snap_ack1, 0);
    drop(0);
    step();
    chk("abort_noack", snap_ack0, 0);
    chk("abort_stb", snap_sstb, 0);
    step();
    chk("abort_idle", snap_busy, 0);
    step();
    chk("abort_next_gnt", snap_gnt, 1);
    chk("abort_next_adr", snap_sadr, 32'h0000_0050);
    bif.s_ack_i = 1'b1;
    step();
    chk("abort_m1_ack", snap_ack1, 1);
    drop(1);
    bif.s_ack_i = 1'b0;
    step();

    // Random traffic across zero-wait, random-wait and dead-slave phases.
    for (int n = 0; n < 3000; n++) begin
      int mode;
      mode = (n / 500) % 3;
      case (mode)
        0:       bif.s_ack_i = 1'b1;
        1:       bif.s_ack_i = ($urandom_range(0, 99) < 30);
        default: bif.s_ack_i = 1'b0;
      endcase
      bif.s_dat_i = $urandom;
      for (int m = 0; m < 2; m++) begin
        logic acked, stb;
        acked = (m == 0) ? snap_ack0 : snap_ack1;
        stb   = (m == 0) ? bif.m0_stb_i : bif.m1_stb_i;
        if (acked) begin
          if ($urandom_range(0, 1) == 1) new_req(m);
          else drop(m);
        end else if (stb) begin
          if ($urandom_range(0, 99) < 2) drop(m);
        end else if ($urandom_range(0, 99) < 30) begin
          new_req(m);
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
